// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Three-stage instruction fetch front end (IF1/IF2/IF3).
//                IF1 holds the PC and issues the synchronous imem read,
//                IF2 catches the read data (buffering it across stalls),
//                IF3 presents instruction and PC to ID under valid/allow-in.
//                Branch redirect and exception flush squash in-flight fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INC   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jbr,
   input  logic [31:0] jbr_target,
   input  logic        flush,
   input  logic [31:0] flush_target,
   input  logic        id_allow_in,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        IF_over,
   output logic [31:0] IF_inst,
   output logic [31:0] IF1_pc,
   output logic [31:0] IF2_pc,
   output logic [31:0] IF3_pc
);

   localparam logic [31:0] PC_STEP    = 32'(PC_INC);
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [31:0] pc_q, pc_d;
   logic [31:0] if2_pc_q, if2_pc_d;
   logic [31:0] if3_pc_q, if3_pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic        v2_q, v2_d;
   logic        v3_q, v3_d;
   logic        fresh2_q, fresh2_d;

   logic        if3_allow;
   logic        if2_allow;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] if2_inst;

   // Handshake chain, fetch enable and redirect target selection (flush wins)
   always_comb begin
      if3_allow   = ~v3_q | id_allow_in;
      if2_allow   = ~v2_q | if3_allow;
      redirect    = jbr | flush;
      imem_en     = ~reset & if2_allow & ~redirect;
      redirect_pc = (flush ? flush_target : jbr_target) & ALIGN_MASK;
      // Read data is only on the bus the cycle after issue; afterwards use the buffered copy
      if2_inst    = fresh2_q ? imem_rdata : inst_buf_q;
   end

   // Next-state computation for PC, IF2 and IF3 stages
   always_comb begin
      pc_d       = pc_q;
      if2_pc_d   = if2_pc_q;
      if3_pc_d   = if3_pc_q;
      inst_d     = inst_q;
      inst_buf_d = inst_buf_q;
      v2_d       = v2_q;
      v3_d       = v3_q;
      fresh2_d   = fresh2_q;
      if (redirect) begin
         // Redirect overrides any stall and squashes everything in flight
         pc_d     = redirect_pc;
         v2_d     = 1'b0;
         v3_d     = 1'b0;
         fresh2_d = 1'b0;
      end else begin
         if (imem_en) begin
            if2_pc_d = pc_q;
            v2_d     = 1'b1;
            fresh2_d = 1'b1;
            pc_d     = pc_q + PC_STEP;
         end else if (v2_q && if3_allow) begin
            v2_d = 1'b0;
         end
         // IF3 blocked while the read data is live: capture it exactly once
         if (v2_q && fresh2_q && !if3_allow) begin
            inst_buf_d = imem_rdata;
            fresh2_d   = 1'b0;
         end
         if (v2_q && if3_allow) begin
            if3_pc_d = if2_pc_q;
            inst_d   = if2_inst;
            v3_d     = 1'b1;
         end else if (id_allow_in && v3_q) begin
            v3_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         if2_pc_q   <= 32'h0;
         if3_pc_q   <= 32'h0;
         inst_q     <= 32'h0;
         inst_buf_q <= 32'h0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         fresh2_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if2_pc_q   <= if2_pc_d;
         if3_pc_q   <= if3_pc_d;
         inst_q     <= inst_d;
         inst_buf_q <= inst_buf_d;
         v2_q       <= v2_d;
         v3_q       <= v3_d;
         fresh2_q   <= fresh2_d;
      end
   end

   assign imem_addr = pc_q;
   assign IF1_pc    = pc_q;
   assign IF2_pc    = if2_pc_q;
   assign IF3_pc    = if3_pc_q;
   assign IF_inst   = inst_q;
   assign IF_over   = v3_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit. A queue of fetched
//                PCs (at most two in flight) predicts fetch enable, fetch
//                address and the instruction stream delivered to ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        jbr;
   logic [31:0] jbr_target;
   logic        flush;
   logic [31:0] flush_target;
   logic        id_allow_in;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        IF_over;
   logic [31:0] IF_inst;
   logic [31:0] IF1_pc;
   logic [31:0] IF2_pc;
   logic [31:0] IF3_pc;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      bit          aged;
   } ent_t;

   ent_t        q[$];
   logic [31:0] exp_fetch;

   if_fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .jbr          (jbr),
      .jbr_target   (jbr_target),
      .flush        (flush),
      .flush_target (flush_target),
      .id_allow_in  (id_allow_in),
      .imem_en      (imem_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .IF_over      (IF_over),
      .IF_inst      (IF_inst),
      .IF1_pc       (IF1_pc),
      .IF2_pc       (IF2_pc),
      .IF3_pc       (IF3_pc)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: word = addr>>2, junk when not enabled
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= imem_addr >> 2;
      else         imem_rdata <= $urandom;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check pre-edge outputs, advance model
   task automatic cycle(input logic a, input logic j, input logic f,
                        input logic [31:0] jt, input logic [31:0] ft);
      logic exp_en;
      logic exp_over;
      @(negedge clk);
      id_allow_in  = a;
      jbr          = j;
      flush        = f;
      jbr_target   = jt;
      flush_target = ft;
      #1;
      exp_en   = !(j || f) && (q.size() < 2 || a);
      exp_over = (q.size() > 0) && q[0].aged;
      chk("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
      if (exp_en) chk("imem_addr", imem_addr, exp_fetch);
      chk("IF_over", {31'b0, IF_over}, {31'b0, exp_over});
      if (exp_over) begin
         chk("IF3_pc", IF3_pc, q[0].pc);
         chk("IF_inst", IF_inst, q[0].pc >> 2);
      end
      if (j || f) begin
         q.delete();
         exp_fetch = (f ? ft : jt) & 32'hFFFF_FFFC;
      end else begin
         if (exp_over && a) void'(q.pop_front());
         foreach (q[i]) q[i].aged = 1'b1;
         if (exp_en) begin
            q.push_back('{pc: exp_fetch, aged: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
         end
      end
   endtask

   task automatic run_seq(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      reset        = 1'b1;
      jbr          = 1'b0;
      flush        = 1'b0;
      jbr_target   = 32'h0;
      flush_target = 32'h0;
      id_allow_in  = 1'b1;
      exp_fetch    = RESET_PC;
      #100;
      #1;
      chk("rst_IF_over", {31'b0, IF_over}, 32'h0);
      chk("rst_imem_en", {31'b0, imem_en}, 32'h0);
      chk("rst_IF1_pc", IF1_pc, RESET_PC);
      chk("rst_IF3_pc", IF3_pc, 32'h0);
      chk("rst_IF_inst", IF_inst, 32'h0);
      @(posedge clk);
      #2 reset = 1'b0;

      // Sequential stream, then a 3-cycle ID stall
      run_seq(4);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      run_seq(4);
      // Taken branch
      cycle(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      run_seq(4);
      // Flush and branch together under stall: flush target wins
      cycle(1'b0, 1'b1, 1'b1, 32'h40, 32'h380);
      run_seq(4);
      // Unaligned branch target
      cycle(1'b1, 1'b1, 1'b0, 32'h43, 32'h0);
      run_seq(4);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 32) == 0,
               $urandom & 32'h0000_0FFF, $urandom & 32'h0000_0FFF);
      end

      // Reset asserted mid-stall with both stages full
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("stall_full", q.size(), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("midrst_IF_over", {31'b0, IF_over}, 32'h0);
      chk("midrst_IF1_pc", IF1_pc, RESET_PC);
      chk("midrst_imem_en", {31'b0, imem_en}, 32'h0);
      q.delete();
      exp_fetch = RESET_PC;
      @(posedge clk);
      #2 reset = 1'b0;
      run_seq(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
